// File: rtl/cell_bist.sv
// BIST controller: a 16-bit LFSR drives patterns into the cell-under-test and a
// 16-bit MISR compacts its responses into a signature that is checked against GOLDEN.
module cell_bist #(
  parameter int          WIDTH_IN     = 4,
  parameter int          WIDTH_OUT    = 1,
  parameter int          NUM_PATTERNS = 16,
  parameter int          RESP_LAT     = 0,
  parameter logic [15:0] LFSR_SEED    = 16'h0001,
  parameter logic [15:0] MISR_SEED    = 16'h0000,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  output logic [WIDTH_IN-1:0]  PAT,
  input  logic [WIDTH_OUT-1:0] RESP,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [15:0]          SIG
);

  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [15:0] LSEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          VW      = (RESP_LAT > 0) ? RESP_LAT : 1;
  localparam logic [15:0] NP_LAST = 16'(NUM_PATTERNS - 1);
  localparam logic [15:0] DR_LAST = 16'(VW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] misr;
  logic [15:0] misr_nxt;
  logic [15:0] resp_ext;
  logic [15:0] cnt;
  logic [VW-1:0] vld_p;
  logic        capture;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] r);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ r;
  endfunction

  always_comb begin
    resp_ext = '0;
    resp_ext[WIDTH_OUT-1:0] = RESP;
  end

  // With a combinational CUT the response belongs to the pattern on PAT right now;
  // otherwise the valid pipe marks when a delayed response arrives.
  assign capture  = (RESP_LAT == 0) ? (state == S_RUN) : vld_p[VW-1];
  assign misr_nxt = capture ? misr_step(misr, resp_ext) : misr;

  always_ff @(posedge CK) begin
    if (RST) begin
      state  <= S_IDLE;
      lfsr   <= LSEED;
      misr   <= MISR_SEED;
      cnt    <= '0;
      vld_p  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      vld_p[0] <= (state == S_RUN);
      for (int i = 1; i < VW; i++) vld_p[i] <= vld_p[i-1];
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state  <= S_RUN;
            lfsr   <= LSEED;
            misr   <= MISR_SEED;
            cnt    <= '0;
            vld_p  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
          end
        end
        S_RUN: begin
          lfsr <= lfsr_step(lfsr);
          misr <= misr_nxt;
          if (cnt == NP_LAST) begin
            cnt <= '0;
            if (RESP_LAT > 0) begin
              state <= S_DRAIN;
            end else begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (misr_nxt == GOLDEN);
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          misr <= misr_nxt;
          if (cnt == DR_LAST) begin
            cnt    <= '0;
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (misr_nxt == GOLDEN);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign PAT  = lfsr[WIDTH_IN-1:0];
  assign SIG  = misr;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;

endmodule

// File: tb/tb_cell_bist.sv
// Scoreboard bench for cell_bist: four instances with different run lengths,
// latencies and golden values share clock, reset and START.
module tb_cell_bist;

  logic CK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  always #5 CK = ~CK;

  logic [3:0][3:0]  pat;
  logic [3:0][15:0] sig;
  logic [3:0]       bsy, dn, ps;
  logic             r1, r2;

  // Two-register stand-in for a pipelined CUT whose output is constant 1.
  always @(posedge CK) begin
    if (RST) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
    end else begin
      r1 <= 1'b1;
      r2 <= r1;
    end
  end

  cell_bist #(.WIDTH_IN(4), .WIDTH_OUT(1), .NUM_PATTERNS(4), .RESP_LAT(0),
              .LFSR_SEED(16'h0001), .MISR_SEED(16'h0000), .GOLDEN(16'h000F)) u_a (
    .CK(CK), .RST(RST), .START(START), .PAT(pat[0]), .RESP(1'b1),
    .BUSY(bsy[0]), .DONE(dn[0]), .PASS(ps[0]), .SIG(sig[0]));

  cell_bist #(.WIDTH_IN(4), .WIDTH_OUT(1), .NUM_PATTERNS(4), .RESP_LAT(2),
              .LFSR_SEED(16'h0001), .MISR_SEED(16'h0000), .GOLDEN(16'h000F)) u_b (
    .CK(CK), .RST(RST), .START(START), .PAT(pat[1]), .RESP(r2),
    .BUSY(bsy[1]), .DONE(dn[1]), .PASS(ps[1]), .SIG(sig[1]));

  cell_bist #(.WIDTH_IN(4), .WIDTH_OUT(1), .NUM_PATTERNS(16), .RESP_LAT(0),
              .LFSR_SEED(16'h0001), .MISR_SEED(16'h0000), .GOLDEN(16'h0000)) u_c (
    .CK(CK), .RST(RST), .START(START), .PAT(pat[2]), .RESP(1'b0),
    .BUSY(bsy[2]), .DONE(dn[2]), .PASS(ps[2]), .SIG(sig[2]));

  cell_bist #(.WIDTH_IN(4), .WIDTH_OUT(1), .NUM_PATTERNS(4), .RESP_LAT(0),
              .LFSR_SEED(16'h0001), .MISR_SEED(16'h0000), .GOLDEN(16'h000E)) u_d (
    .CK(CK), .RST(RST), .START(START), .PAT(pat[3]), .RESP(1'b1),
    .BUSY(bsy[3]), .DONE(dn[3]), .PASS(ps[3]), .SIG(sig[3]));

  typedef struct packed {
    logic [3:0]  pat;
    logic [15:0] sig;
  } cyc_t;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
    logic [7:0]  len;
  } done_t;

  // Low nibble of the LFSR from seed 1: 0001,0002,...,0400,0801,1002,2005,400B,8016.
  localparam logic [3:0]  PATS [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0,
                                        4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h5, 4'hB, 4'h6};
  localparam logic [15:0] SIG_A [4] = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};
  localparam logic [15:0] SIG_B [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001,
                                        16'h0003, 16'h0007};

  cyc_t  qc [4][$];
  done_t qd [4][$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Monitor: consumes one cycle expectation per BUSY cycle and one done record per DONE rise.
  logic [3:0] bsy_q = '0;
  logic [3:0] dn_q  = '0;
  int         blen [4];
  always @(negedge CK) begin
    cyc_t  c;
    done_t d;
    for (int i = 0; i < 4; i++) begin
      if (bsy[i] && !bsy_q[i]) blen[i] = 0;
      if (bsy[i]) begin
        blen[i]++;
        chk("busy_and_done", i, 32'(dn[i]), 32'd0);
        if (qc[i].size() == 0) begin
          chk("unexpected_busy_cycle", i, 32'(blen[i]), 32'd0);
        end else begin
          c = qc[i].pop_front();
          chk("pat", i, 32'(pat[i]), 32'(c.pat));
          chk("sig_run", i, 32'(sig[i]), 32'(c.sig));
        end
      end
      if (!dn[i]) chk("pass_without_done", i, 32'(ps[i]), 32'd0);
      if (dn[i] && !dn_q[i]) begin
        if (qd[i].size() == 0) begin
          chk("unexpected_done", i, 32'(dn[i]), 32'd0);
        end else begin
          d = qd[i].pop_front();
          chk("sig_final", i, 32'(sig[i]), 32'(d.sig));
          chk("pass", i, 32'(ps[i]), 32'(d.pass));
          chk("busy_len", i, 32'(blen[i]), 32'(d.len));
        end
      end
    end
    bsy_q = bsy;
    dn_q  = dn;
  end

  task automatic push_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      if (k < 4) begin
        qc[0].push_back('{pat: PATS[k], sig: SIG_A[k]});
        qc[3].push_back('{pat: PATS[k], sig: SIG_A[k]});
      end
      if (k < 6) qc[1].push_back('{pat: PATS[(k < 4) ? k : 4], sig: SIG_B[k]});
      if (k < 16) qc[2].push_back('{pat: PATS[k], sig: 16'h0000});
    end
  endtask

  task automatic push_run();
    push_cycles(16);
    qd[0].push_back('{sig: 16'h000F, pass: 1'b1, len: 8'd4});
    qd[1].push_back('{sig: 16'h000F, pass: 1'b1, len: 8'd6});
    qd[2].push_back('{sig: 16'h0000, pass: 1'b1, len: 8'd16});
    qd[3].push_back('{sig: 16'h000F, pass: 1'b0, len: 8'd4});
  endtask

  task automatic start_pulse();
    @(posedge CK) #1 START = 1'b1;
    @(posedge CK) #1 START = 1'b0;
  endtask

  task automatic wait_all_done();
    int n = 0;
    while (dn != 4'hF && n < 200) begin
      @(negedge CK);
      n++;
    end
    if (dn != 4'hF) chk("done_timeout", 0, 32'(dn), 32'hF);
    @(negedge CK);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, i, 32'(bsy[i]), 32'd0);
      chk({tag, "_done"}, i, 32'(dn[i]), 32'd0);
      chk({tag, "_pass"}, i, 32'(ps[i]), 32'd0);
      chk({tag, "_sig"}, i, 32'(sig[i]), 32'h0000);
      chk({tag, "_pat"}, i, 32'(pat[i]), 32'h1);
    end
  endtask

  initial begin
    repeat (3) @(posedge CK);
    #1 RST = 1'b0;
    @(negedge CK);
    check_idle("reset");
    repeat (10) @(negedge CK);
    check_idle("idle");

    // Uninterrupted run.
    push_run();
    start_pulse();
    wait_all_done();

    // Restart from DONE, with a stray START during RUN cycle 2.
    push_run();
    start_pulse();
    @(negedge CK);
    for (int i = 0; i < 4; i++) begin
      chk("restart_busy", i, 32'(bsy[i]), 32'd1);
      chk("restart_done", i, 32'(dn[i]), 32'd0);
      chk("restart_pass", i, 32'(ps[i]), 32'd0);
    end
    @(posedge CK);
    @(posedge CK) #1 START = 1'b1;
    @(posedge CK) #1 START = 1'b0;
    wait_all_done();

    // Abort during RUN cycle 3, then a clean run must match the uninterrupted one.
    push_cycles(4);
    start_pulse();
    @(posedge CK);
    @(posedge CK);
    @(posedge CK) #1 RST = 1'b1;
    @(posedge CK) #1 RST = 1'b0;
    @(negedge CK);
    check_idle("abort");
    repeat (3) @(posedge CK);
    push_run();
    start_pulse();
    wait_all_done();

    for (int i = 0; i < 4; i++) begin
      chk("leftover_cycles", i, 32'(qc[i].size()), 32'd0);
      chk("leftover_done", i, 32'(qd[i].size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
